// File: rtl/commutation_pkg.sv
// Shared codes, state encodings and gate-pattern helpers for the matrix-converter commutation sequencer.
// Latency: none; this file holds only types and pure functions.
// Backpressure: not applicable.
package commutation_pkg;

    // Output-leg target codes: which input phase the leg connects to.
    localparam logic [1:0] NUL = 2'b00;
    localparam logic [1:0] LAA = 2'b01;
    localparam logic [1:0] LBB = 2'b10;
    localparam logic [1:0] LCC = 2'b11;

    typedef enum logic [2:0] {
        STEADY = 3'd0,
        S1     = 3'd1,
        S2     = 3'd2,
        S3     = 3'd3,
        S4     = 3'd4
    } leg_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } top_state_t;

    // Places a fwd/rev device pair into the 6-bit leg slice at the
    // position of the switch selected by code; NUL selects no switch.
    function automatic logic [5:0] switch_bits(input logic [1:0] code,
                                               input logic fwd_on,
                                               input logic rev_on);
        logic [5:0] v;
        v = '0;
        case (code)
            LAA:     v[1:0] = {rev_on, fwd_on};
            LBB:     v[3:2] = {rev_on, fwd_on};
            LCC:     v[5:4] = {rev_on, fwd_on};
            default: v      = '0;
        endcase
        return v;
    endfunction

    // Gate pattern for one leg. The conducting device is fwd when the
    // current is positive (s=1), rev otherwise; "only conducting on" is
    // therefore the pair (s, ~s). Steps are cumulative, so each state
    // describes the full set of devices on at that point.
    function automatic logic [5:0] leg_gates(input leg_state_t st,
                                             input logic [1:0] cur,
                                             input logic [1:0] tgt,
                                             input logic       s);
        logic [5:0] v;
        v = '0;
        case (st)
            STEADY:  v = switch_bits(cur, 1'b1, 1'b1);
            S1:      v = switch_bits(cur, s, ~s);
            S2:      v = switch_bits(cur, s, ~s) | switch_bits(tgt, s, ~s);
            S3:      v = switch_bits(tgt, s, ~s);
            S4:      v = switch_bits(tgt, 1'b1, 1'b1);
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/commutation_leg.sv
// One output leg: four-step current-sign commutation between input phases.
// Latency: gate slice registered; a change of phase completes 4*STEP_CYCLES edges after it is seen.
// Backpressure: none; target/sign are ignored while a commutation is in flight.
module commutation_leg
    import commutation_pkg::*;
#(
    parameter int STEP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clear,
    input  logic [1:0] target,
    input  logic       sign,
    output logic [5:0] gates
);

    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    leg_state_t    state, state_nxt;
    logic [1:0]    cur, cur_nxt;
    logic [1:0]    tgt, tgt_nxt;
    logic          s, s_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          dwell_done;

    assign dwell_done = (cnt == CW'(STEP_CYCLES - 1));

    // Next-state: start a commutation on a target change, then walk S1..S4
    // with one dwell each; clear drops the leg back to an open, idle NUL.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        tgt_nxt   = tgt;
        s_nxt     = s;
        cnt_nxt   = cnt;
        if (clear) begin
            state_nxt = STEADY;
            cur_nxt   = NUL;
            tgt_nxt   = NUL;
            s_nxt     = 1'b0;
            cnt_nxt   = '0;
        end else if (enable) begin
            if (state == STEADY) begin
                if (target != cur) begin
                    state_nxt = S1;
                    tgt_nxt   = target;
                    s_nxt     = sign;
                    cnt_nxt   = '0;
                end
            end else if (!dwell_done) begin
                cnt_nxt = cnt + CW'(1);
            end else begin
                cnt_nxt = '0;
                case (state)
                    S1:      state_nxt = S2;
                    S2:      state_nxt = S3;
                    S3:      state_nxt = S4;
                    S4: begin
                        state_nxt = STEADY;
                        cur_nxt   = tgt;
                    end
                    default: state_nxt = STEADY;
                endcase
            end
        end
    end

    // State and registered gate slice, computed from the next state so the
    // drive for a step appears on the same edge the step is entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= STEADY;
            cur   <= NUL;
            tgt   <= NUL;
            s     <= 1'b0;
            cnt   <= '0;
            gates <= '0;
        end else begin
            state <= state_nxt;
            cur   <= cur_nxt;
            tgt   <= tgt_nxt;
            s     <= s_nxt;
            cnt   <= cnt_nxt;
            gates <= leg_gates(state_nxt, cur_nxt, tgt_nxt, s_nxt);
        end
    end

endmodule

// File: rtl/top_commutation.sv
// Gate-drive sequencer for a 3x3 matrix converter: run/idle/fault control over three commutating legs.
// Latency: Sout registered; start drop or short forces Sout=0 on the edge that samples it.
// Backpressure: none; a short latches shutdown until reset.
module top_commutation
    import commutation_pkg::*;
#(
    parameter int STEP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  shorts,
    input  logic [2:0]  CurrentSign,
    input  logic [5:0]  DesiredLoad,
    output logic [17:0] Sout,
    output logic        short
);

    top_state_t state, state_nxt;
    logic       run_nxt;
    logic [5:0] leg_slice [3];

    // Top FSM next state: a short wins over start, and FAULT only leaves via reset.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (|shorts)    state_nxt = FAULT;
                else if (start) state_nxt = RUN;
            end
            RUN: begin
                if (|shorts)     state_nxt = FAULT;
                else if (!start) state_nxt = IDLE;
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    // Legs advance only on edges that leave the FSM in RUN; every other edge
    // opens all switches, so Sout goes to zero on the very edge that stops us.
    assign run_nxt = (state_nxt == RUN);

    // Top state register and latched fault flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            short <= 1'b0;
        end else begin
            state <= state_nxt;
            short <= (state_nxt == FAULT);
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_leg
        commutation_leg #(
            .STEP_CYCLES(STEP_CYCLES)
        ) u_leg (
            .clk    (clk),
            .rst    (rst),
            .enable (run_nxt),
            .clear  (!run_nxt),
            .target (DesiredLoad[2*k+1:2*k]),
            .sign   (CurrentSign[k]),
            .gates  (leg_slice[k])
        );
    end

    assign Sout = {leg_slice[2], leg_slice[1], leg_slice[0]};

endmodule

// File: tb/tb_top_commutation.sv
// Self-checking bench for top_commutation: directed scenarios plus random traffic against a timeline model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_top_commutation;

    localparam int SC = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  shorts;
    logic [2:0]  CurrentSign;
    logic [5:0]  DesiredLoad;
    logic [17:0] Sout;
    logic        short;

    int checks;
    int errors;

    top_commutation #(.STEP_CYCLES(SC)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .shorts      (shorts),
        .CurrentSign (CurrentSign),
        .DesiredLoad (DesiredLoad),
        .Sout        (Sout),
        .short       (short)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: 0=idle 1=run 2=fault; each leg is either settled on
    // a phase or somewhere along a timeline measured in elapsed cycles.
    int m_mode;
    int m_cur [3];
    int m_old [3];
    int m_new [3];
    int m_el  [3];
    bit m_busy[3];
    bit m_sg  [3];

    task automatic model_reset();
        m_mode = 0;
        for (int k = 0; k < 3; k++) begin
            m_cur[k] = 0; m_old[k] = 0; m_new[k] = 0; m_el[k] = 0;
            m_busy[k] = 1'b0; m_sg[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int nm;
        int d;
        if (m_mode == 2 || shorts != 3'b000) nm = 2;
        else if (start)                      nm = 1;
        else                                 nm = 0;
        for (int k = 0; k < 3; k++) begin
            if (nm != 1) begin
                m_cur[k] = 0; m_busy[k] = 1'b0; m_el[k] = 0;
            end else if (m_busy[k]) begin
                m_el[k] = m_el[k] + 1;
                if (m_el[k] == 4 * SC) begin
                    m_cur[k]  = m_new[k];
                    m_busy[k] = 1'b0;
                end
            end else begin
                d = int'(DesiredLoad[2*k +: 2]);
                if (d != m_cur[k]) begin
                    m_busy[k] = 1'b1;
                    m_el[k]   = 0;
                    m_old[k]  = m_cur[k];
                    m_new[k]  = d;
                    m_sg[k]   = CurrentSign[k];
                end
            end
        end
        m_mode = nm;
    endtask

    function automatic logic [17:0] model_sout();
        logic [17:0] v;
        int b, stp, oc, nc;
        v = '0;
        if (m_mode == 1) begin
            for (int k = 0; k < 3; k++) begin
                b = 6 * k;
                if (!m_busy[k]) begin
                    if (m_cur[k] != 0) begin
                        v[b + 2*(m_cur[k]-1)]     = 1'b1;
                        v[b + 2*(m_cur[k]-1) + 1] = 1'b1;
                    end
                end else begin
                    stp = m_el[k] / SC;
                    oc  = m_sg[k] ? 0 : 1;
                    nc  = 1 - oc;
                    // Old non-conducting is off from the first step; old
                    // conducting stays through the overlap; new conducting
                    // joins at step 2 and new non-conducting at step 4.
                    if (m_old[k] != 0 && stp < 2) v[b + 2*(m_old[k]-1) + oc] = 1'b1;
                    if (m_new[k] != 0 && stp >= 1) v[b + 2*(m_new[k]-1) + oc] = 1'b1;
                    if (m_new[k] != 0 && stp >= 3) v[b + 2*(m_new[k]-1) + nc] = 1'b1;
                end
            end
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%05h expected=0x%05h", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, "_sout"}, Sout, model_sout());
        chk({tag, "_short"}, {17'b0, short}, {17'b0, (m_mode == 2)});
    endtask

    initial begin
        logic [17:0] exp_final;
        checks = 0;
        errors = 0;
        rst = 1'b0; start = 1'b0; shorts = 3'b000; CurrentSign = 3'b000; DesiredLoad = 6'b000000;
        model_reset();
        #12;
        chk("reset_sout", Sout, 18'h0);
        chk("reset_short", {17'b0, short}, 18'h0);
        @(negedge clk);
        rst = 1'b1;

        // Idle: outputs stay off whatever the load request.
        for (int i = 0; i < 10; i++) begin
            DesiredLoad = 6'($urandom); CurrentSign = 3'($urandom);
            tick("idle");
        end

        // NUL -> A on leg 0 with positive current.
        start = 1'b1; DesiredLoad = 6'b000001; CurrentSign = 3'b111;
        for (int i = 1; i <= 4 * SC; i++) begin
            tick("nul2a");
            if (i == SC + 1) chk("nul2a_s2", Sout, 18'h00001);
            if (i == 4 * SC) chk("nul2a_final", Sout, 18'h00003);
        end
        tick("nul2a_hold");

        // A -> B, positive current.
        DesiredLoad = 6'b000010; CurrentSign = 3'b001;
        for (int i = 1; i <= 4 * SC; i++) begin
            tick("a2b_pos");
            if (i == 1)          chk("a2b_pos_s1", Sout, 18'h01);
            if (i == SC + 1)     chk("a2b_pos_s2", Sout, 18'h05);
            if (i == 2 * SC + 1) chk("a2b_pos_s3", Sout, 18'h04);
            if (i == 4 * SC)     chk("a2b_pos_end", Sout, 18'h0C);
        end

        // Back to A, then A -> B with negative current.
        DesiredLoad = 6'b000001;
        for (int i = 0; i < 4 * SC + 2; i++) tick("b2a");
        DesiredLoad = 6'b000010; CurrentSign = 3'b000;
        for (int i = 1; i <= 4 * SC; i++) begin
            tick("a2b_neg");
            if (i == 1)          chk("a2b_neg_s1", Sout, 18'h02);
            if (i == SC + 1)     chk("a2b_neg_s2", Sout, 18'h0A);
            if (i == 2 * SC + 1) chk("a2b_neg_s3", Sout, 18'h08);
            if (i == 4 * SC)     chk("a2b_neg_end", Sout, 18'h0C);
        end

        // All legs to A, then parallel commutation with a mid-sequence request change.
        DesiredLoad = 6'b010101; CurrentSign = 3'($urandom);
        for (int i = 0; i < 4 * SC + 2; i++) tick("all_a");
        DesiredLoad = 6'b111000; CurrentSign = 3'($urandom);
        for (int i = 1; i <= 4 * SC; i++) begin
            if (i == 6) begin
                DesiredLoad = 6'($urandom); CurrentSign = 3'($urandom);
            end
            tick("parallel");
        end
        exp_final = (18'h30 << 12) | (18'h0C << 6);
        chk("parallel_final", Sout, exp_final);
        DesiredLoad = 6'b111000;
        for (int i = 0; i < 4 * SC + 2; i++) tick("parallel_settle");

        // Drop start mid-commutation, then restart cleanly from NUL.
        DesiredLoad = 6'b010101; CurrentSign = 3'b101;
        for (int i = 0; i < 6; i++) tick("pre_drop");
        start = 1'b0;
        tick("drop");
        chk("drop_off", Sout, 18'h0);
        start = 1'b1;
        for (int i = 0; i < 4 * SC; i++) tick("restart");
        chk("restart_final", Sout, 18'h030C3);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7, 0) == 0) DesiredLoad = 6'($urandom);
            CurrentSign = 3'($urandom);
            start = ($urandom_range(39, 0) != 0);
            tick("rand");
        end

        // Short during RUN latches shutdown until reset.
        start = 1'b1; DesiredLoad = 6'($urandom);
        for (int i = 0; i < 7; i++) tick("pre_fault");
        shorts = 3'b010;
        tick("fault");
        chk("fault_sout", Sout, 18'h0);
        chk("fault_flag", {17'b0, short}, 18'h1);
        shorts = 3'b000;
        for (int i = 0; i < 8; i++) begin
            start = i[0];
            DesiredLoad = 6'($urandom);
            tick("fault_hold");
        end
        chk("fault_latched", {17'b0, short}, 18'h1);

        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst2_sout", Sout, 18'h0);
        chk("rst2_short", {17'b0, short}, 18'h0);
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        for (int i = 0; i < 3; i++) tick("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
